// File: rtl/pf_mem_req_dispatch_if.sv
// Prefetch op input plus the L2/L3 request channels and L1 drop count.
// The slave modport is the dispatcher side; master is the producer/consumer side.
interface pf_mem_req_dispatch_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              valid_i;
    logic              ready_o;
    logic [7:0]        mod_i;
    logic [7:0]        instr_i;
    logic [ADDR_W-1:0] src_i;
    logic [ADDR_W-1:0] dst_i;
    logic              l2_req_v_o;
    logic              l2_req_rdy_i;
    logic [ADDR_W-1:0] l2_addr_o;
    logic              l2_store_o;
    logic              l3_req_v_o;
    logic              l3_req_rdy_i;
    logic [ADDR_W-1:0] l3_addr_o;
    logic              l3_store_o;
    logic [CNT_W-1:0]  l1_cnt_o;

    modport slave (
        input  valid_i, mod_i, instr_i, src_i, dst_i, l2_req_rdy_i, l3_req_rdy_i,
        output ready_o, l2_req_v_o, l2_addr_o, l2_store_o,
               l3_req_v_o, l3_addr_o, l3_store_o, l1_cnt_o
    );

    modport master (
        output valid_i, mod_i, instr_i, src_i, dst_i, l2_req_rdy_i, l3_req_rdy_i,
        input  ready_o, l2_req_v_o, l2_addr_o, l2_store_o,
               l3_req_v_o, l3_addr_o, l3_store_o, l1_cnt_o
    );
endinterface

// File: rtl/pf_mem_req_dispatch.sv
// Classifies prefetch ops into L1 (counted drop), L2 or L3, queues L2/L3 requests
// in per-level FIFOs and drains each through its own valid/ready channel.
module pf_mem_req_dispatch #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pf_mem_req_dispatch_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + 1;
    localparam int NLVL  = 2;

    logic              store;
    logic              l3;
    logic              l2;
    logic              l1;
    logic [ADDR_W-1:0] addr;
    logic [ENT_W-1:0]  entry;
    logic              accept;
    logic [NLVL-1:0]   push;
    logic [NLVL-1:0]   pop;
    logic [NLVL-1:0]   full;
    logic [NLVL-1:0]   empty;
    logic [NLVL-1:0]   rdy;
    logic [ENT_W-1:0]  head [NLVL];
    logic [CNT_W-1:0]  l1_cnt_reg;
    logic              unused_bits;

    always_comb begin
        store = &bus.instr_i[7:4];
        l3    = store ? (&bus.mod_i[7:5]) : (bus.src_i == bus.dst_i);
        l2    = ~|bus.mod_i[1:0] & ~l3;
        l1    = ~l2 & ~l3;
        addr  = store ? bus.dst_i : bus.src_i;
        entry = {store, addr};
    end

    // Shift field and low opcode bits carry no meaning for classification.
    assign unused_bits = ^{bus.mod_i[4:2], bus.instr_i[3:0]};

    // Registered full flags only, so even an L1 op waits while either queue is full.
    assign bus.ready_o = ~full[0] & ~full[1];
    assign accept      = bus.valid_i & bus.ready_o;
    assign push        = {accept & l3, accept & l2};
    assign rdy         = {bus.l3_req_rdy_i, bus.l2_req_rdy_i};

    // Level 0 is L2, level 1 is L3.
    generate
        for (genvar gi = 0; gi < NLVL; gi++) begin : g_lvl
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [ENT_W-1:0] mem_reg [DEPTH];

            assign full[gi]  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                               (wr_ptr_reg[PTR_W-2:0] == rd_ptr_reg[PTR_W-2:0]);
            assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign pop[gi]   = ~empty[gi] & rdy[gi];
            assign head[gi]  = mem_reg[rd_ptr_reg[PTR_W-2:0]];

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                end else begin
                    if (push[gi]) begin
                        mem_reg[wr_ptr_reg[PTR_W-2:0]] <= entry;
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                end
            end
        end
    endgenerate

    assign bus.l2_req_v_o = ~empty[0];
    assign bus.l2_addr_o  = head[0][ADDR_W-1:0];
    assign bus.l2_store_o = head[0][ADDR_W];
    assign bus.l3_req_v_o = ~empty[1];
    assign bus.l3_addr_o  = head[1][ADDR_W-1:0];
    assign bus.l3_store_o = head[1][ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            l1_cnt_reg <= '0;
        end else if (accept && l1 && !(&l1_cnt_reg)) begin
            l1_cnt_reg <= l1_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.l1_cnt_o = l1_cnt_reg;

endmodule

// File: tb/tb_pf_mem_req_dispatch.sv
// Directed bench for pf_mem_req_dispatch: decode, FIFO fill/wrap, backpressure,
// L1 saturation and mid-traffic reset, with hand-computed expectations.
module tb_pf_mem_req_dispatch;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pf_mem_req_dispatch_if #(.ADDR_W(8), .CNT_W(8)) bus ();

    pf_mem_req_dispatch #(.ADDR_W(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("check %s ok: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [7:0] m, input logic [7:0] ins,
                      input logic [7:0] s, input logic [7:0] d);
        bus.valid_i = v;
        bus.mod_i   = m;
        bus.instr_i = ins;
        bus.src_i   = s;
        bus.dst_i   = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        bus.l2_req_rdy_i = 1'b0;
        bus.l3_req_rdy_i = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_l2v", 32'(bus.l2_req_v_o), 32'd0);
        chk("rst_l3v", 32'(bus.l3_req_v_o), 32'd0);
        chk("rst_cnt", 32'(bus.l1_cnt_o), 32'd0);
        chk("rst_l2addr", 32'(bus.l2_addr_o), 32'd0);

        // 1: plain load to L2, registered latency
        op(1'b1, 8'h00, 8'h10, 8'd3, 8'd5);
        chk("t1_l2v_same_cycle", 32'(bus.l2_req_v_o), 32'd0);
        step();
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t1_l2v", 32'(bus.l2_req_v_o), 32'd1);
        chk("t1_l2addr", 32'(bus.l2_addr_o), 32'd3);
        chk("t1_l2store", 32'(bus.l2_store_o), 32'd0);
        chk("t1_cnt", 32'(bus.l1_cnt_o), 32'd0);
        chk("t1_l3v", 32'(bus.l3_req_v_o), 32'd0);
        bus.l2_req_rdy_i = 1'b1;
        step();
        bus.l2_req_rdy_i = 1'b0;
        chk("t1_l2v_popped", 32'(bus.l2_req_v_o), 32'd0);

        // 2: L3 via src==dst, L3 store, store with weak cond going to L2
        op(1'b1, 8'h00, 8'h10, 8'd7, 8'd7);
        step();
        op(1'b1, 8'hE1, 8'hF2, 8'd4, 8'd9);
        chk("t2_l3v", 32'(bus.l3_req_v_o), 32'd1);
        chk("t2_l3addr", 32'(bus.l3_addr_o), 32'd7);
        chk("t2_l3store", 32'(bus.l3_store_o), 32'd0);
        step();
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t2_l3_head_hold", 32'(bus.l3_addr_o), 32'd7);
        chk("t2_l2v", 32'(bus.l2_req_v_o), 32'd0);
        bus.l3_req_rdy_i = 1'b1;
        step();
        chk("t2_st_addr", 32'(bus.l3_addr_o), 32'd9);
        chk("t2_st_store", 32'(bus.l3_store_o), 32'd1);
        step();
        bus.l3_req_rdy_i = 1'b0;
        chk("t2_l3_empty", 32'(bus.l3_req_v_o), 32'd0);
        op(1'b1, 8'hD0, 8'hF0, 8'd1, 8'd2);
        step();
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t2_st_l2v", 32'(bus.l2_req_v_o), 32'd1);
        chk("t2_st_l2addr", 32'(bus.l2_addr_o), 32'd2);
        chk("t2_st_l2store", 32'(bus.l2_store_o), 32'd1);
        chk("t2_st_l3v", 32'(bus.l3_req_v_o), 32'd0);
        bus.l2_req_rdy_i = 1'b1;
        step();
        bus.l2_req_rdy_i = 1'b0;

        // 3: fill L2, then stream through with wrap
        for (int k = 0; k < 4; k++) begin
            op(1'b1, 8'h00, 8'h00, 8'(10 + k), 8'h00);
            step();
        end
        op(1'b1, 8'h00, 8'h00, 8'd14, 8'h00);
        chk("t3_full_ready", 32'(bus.ready_o), 32'd0);
        chk("t3_head", 32'(bus.l2_addr_o), 32'd10);
        bus.l2_req_rdy_i = 1'b1;
        step();
        chk("t3_after_pop_head", 32'(bus.l2_addr_o), 32'd11);
        for (int k = 4; k < 12; k++) begin
            op(1'b1, 8'h00, 8'h00, 8'(10 + k), 8'h00);
            chk($sformatf("t3_ready_%0d", k), 32'(bus.ready_o), 32'd1);
            step();
            chk($sformatf("t3_head_%0d", k), 32'(bus.l2_addr_o), 32'(8 + k));
        end
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t3_drain_v_%0d", j), 32'(bus.l2_req_v_o), 32'd1);
            chk($sformatf("t3_drain_addr_%0d", j), 32'(bus.l2_addr_o), 32'(19 + j));
            step();
        end
        chk("t3_drained", 32'(bus.l2_req_v_o), 32'd0);
        bus.l2_req_rdy_i = 1'b0;

        // 4: L1 drops saturate the counter
        op(1'b1, 8'h01, 8'h00, 8'd1, 8'd2);
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 1)   chk("t4_cnt_1", 32'(bus.l1_cnt_o), 32'd1);
            if (i == 255) chk("t4_cnt_255", 32'(bus.l1_cnt_o), 32'hFF);
            if (i == 300) chk("t4_cnt_sat", 32'(bus.l1_cnt_o), 32'hFF);
        end
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t4_l2v", 32'(bus.l2_req_v_o), 32'd0);
        chk("t4_l3v", 32'(bus.l3_req_v_o), 32'd0);

        // 5: L3 full blocks an L2 op until one L3 pop
        for (int k = 0; k < 4; k++) begin
            op(1'b1, 8'h00, 8'h00, 8'(8'h40 + k), 8'(8'h40 + k));
            step();
        end
        op(1'b1, 8'h00, 8'h00, 8'h55, 8'h56);
        chk("t5_ready0", 32'(bus.ready_o), 32'd0);
        step();
        chk("t5_ready1", 32'(bus.ready_o), 32'd0);
        chk("t5_l2v_blocked", 32'(bus.l2_req_v_o), 32'd0);
        bus.l3_req_rdy_i = 1'b1;
        step();
        bus.l3_req_rdy_i = 1'b0;
        chk("t5_ready_after_pop", 32'(bus.ready_o), 32'd1);
        chk("t5_l2v_pre", 32'(bus.l2_req_v_o), 32'd0);
        step();
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t5_l2v", 32'(bus.l2_req_v_o), 32'd1);
        chk("t5_l2addr", 32'(bus.l2_addr_o), 32'h55);
        chk("t5_l3head", 32'(bus.l3_addr_o), 32'h41);

        // 6: two entries per FIFO, then reset mid-traffic
        bus.l2_req_rdy_i = 1'b1;
        bus.l3_req_rdy_i = 1'b1;
        repeat (3) step();
        bus.l2_req_rdy_i = 1'b0;
        bus.l3_req_rdy_i = 1'b0;
        chk("t6_drained", 32'({bus.l2_req_v_o, bus.l3_req_v_o}), 32'd0);
        op(1'b1, 8'h00, 8'h00, 8'h60, 8'h00); step();
        op(1'b1, 8'h00, 8'h00, 8'h61, 8'h00); step();
        op(1'b1, 8'h00, 8'h00, 8'h70, 8'h70); step();
        op(1'b1, 8'h00, 8'h00, 8'h71, 8'h71); step();
        chk("t6_pre_l2", 32'(bus.l2_addr_o), 32'h60);
        chk("t6_pre_l3", 32'(bus.l3_addr_o), 32'h70);
        rst = 1'b1;
        op(1'b1, 8'h00, 8'h00, 8'h99, 8'h00);
        step();
        rst = 1'b0;
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t6_l2v", 32'(bus.l2_req_v_o), 32'd0);
        chk("t6_l3v", 32'(bus.l3_req_v_o), 32'd0);
        chk("t6_cnt", 32'(bus.l1_cnt_o), 32'd0);
        chk("t6_ready", 32'(bus.ready_o), 32'd1);
        chk("t6_l2addr", 32'(bus.l2_addr_o), 32'd0);
        chk("t6_l3addr", 32'(bus.l3_addr_o), 32'd0);
        chk("t6_l3store", 32'(bus.l3_store_o), 32'd0);
        op(1'b1, 8'h00, 8'h00, 8'h33, 8'h33);
        step();
        op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("t6_new_l3v", 32'(bus.l3_req_v_o), 32'd1);
        chk("t6_new_l3addr", 32'(bus.l3_addr_o), 32'h33);
        chk("t6_new_l2v", 32'(bus.l2_req_v_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
